node_input_loader: RTL

//  Upstream feeder for the node stage. Collects a serial stream of signed

---
 rtl/node_input_loader.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/node_input_loader.sv
// node_input_loader
//   Upstream feeder for the node stage. Collects a serial stream of signed
//   samples into a DEPTH-entry register bank (in_val). Once the bank is full it
//   steps cnt_val 0..DEPTH to sequence the node's MAC sweep, pulses frame_done
//   for one cycle and re-arms for the next frame.
//
//   Optional feature macro: NODE_LOADER_OVERRUN_EN
//     Adds a sticky 'overrun' output, set on any cycle with in_valid=1 while
//     in_ready=0; cleared only by n_rst or flush (set wins over flush).
//
// Ports
//   clk         in   system clock, rising edge
//   n_rst       in   async active-low reset
//   flush       in   sync abort: drop partial frame, restart load
//   in_data     in   [DATA_W-1:0] sample from upstream
//   in_valid    in   in_data valid
//   in_ready    out  loader can accept in_data (decoded from state register)
//   in_val      out  [DEPTH-1:0] x [DATA_W-1:0] sample bank to the node
//   cnt_val     out  [CNT_W-1:0] sweep index to the node
//   sweep_busy  out  high while cnt_val is stepping
//   frame_done  out  1-cycle pulse at end of sweep
//   overrun     out  sticky dropped-handshake flag (NODE_LOADER_OVERRUN_EN only)
//
// States
//   S_LOAD  | accepting samples into bank, cnt_val held at 0
//   S_SWEEP | bank frozen, cnt_val steps 0..DEPTH
//   S_DONE  | one cycle, frame_done high, cnt_val held at DEPTH
module node_input_loader #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 64,
  parameter int CNT_W  = 7
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     flush,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic signed [DATA_W-1:0] in_val [DEPTH-1:0],
  output logic [CNT_W-1:0]         cnt_val,
  output logic                     sweep_busy,
  output logic                     frame_done
`ifdef NODE_LOADER_OVERRUN_EN
  ,
  output logic                     overrun
`endif
);

  localparam int               IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_SWEEP = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e                    state_q;
  logic [IDX_W-1:0]          wr_idx_q;
  logic [CNT_W-1:0]          cnt_q;
  logic                      busy_q;
  logic                      done_q;
  logic signed [DATA_W-1:0]  bank_q [DEPTH-1:0];

  assign in_ready   = (state_q == S_LOAD);
  assign cnt_val    = cnt_q;
  assign sweep_busy = busy_q;
  assign frame_done = done_q;
  assign in_val     = bank_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= S_LOAD;
      wr_idx_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        bank_q[i] <= '0;
      end
    end else if (flush) begin
      // Abort wins over any accept or transition; bank contents are kept.
      state_q  <= S_LOAD;
      wr_idx_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        S_LOAD: begin
          cnt_q  <= '0;
          busy_q <= 1'b0;
          done_q <= 1'b0;
          if (in_valid) begin
            bank_q[wr_idx_q] <= in_data;
            if (wr_idx_q == IDX_LAST) begin
              wr_idx_q <= '0;
              state_q  <= S_SWEEP;
              busy_q   <= 1'b1;
            end else begin
              wr_idx_q <= wr_idx_q + 1'b1;
            end
          end
        end
        S_SWEEP: begin
          if (cnt_q == CNT_LAST) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_LOAD;
          cnt_q   <= '0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q  <= S_LOAD;
          wr_idx_q <= '0;
          cnt_q    <= '0;
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
        end
      endcase
    end
  end

`ifdef NODE_LOADER_OVERRUN_EN
  logic overrun_q;

  assign overrun = overrun_q;

  // A dropped handshake in the same cycle as a flush must still be reported.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      overrun_q <= 1'b0;
    end else if (in_valid && (state_q != S_LOAD)) begin
      overrun_q <= 1'b1;
    end else if (flush) begin
      overrun_q <= 1'b0;
    end
  end
`endif

endmodule
